mult_nxn_fast: RTL
==================

# mult_nxn_fast

Parametrised multi-cycle unsigned multiplier with a built-in controller and datapath. It is the generalised successor to the fixed 32x32 zero-word-skipping multiplier FSM. Each operand is split into K = WIDTH/CHUNK chunks. One CHUNK x CHUNK partial product is accumulated per cycle, and any chunk pair with a zero chunk is skipped. The block sits beside the ALU as a shared long-latency unit with a start/busy/done handshake and an optional multiply-accumulate mode.

## Interface
- WIDTH, 32, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 16, partial-multiplier width in bits; K = WIDTH/CHUNK, K >= 1.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high.
- start  input  1  request a multiply; sampled only in IDLE.
- accumulate  input  1  sampled with start: 1 keeps the old product and adds to it, 0 clears the product first.
- a  input  WIDTH  multiplicand; captured on the accepting edge.
- b  input  WIDTH  multiplier; captured on the accepting edge.
- busy  output  1  high while in CALC.
- done  output  1  one-cycle pulse when the product is final.
- product  output  2*WIDTH  product/accumulator register.

## Operation
- Reset values: state=IDLE, busy=0, done=0, product=0, internal operand registers and pair pointer = 0.
- Chunks: a_i = a[CHUNK*i +: CHUNK], b_j likewise, for i, j in 0..K-1.
- Pair (i,j) is valid iff a_i != 0 and b_j != 0.
- Pairs are visited in ascending p = i*K + j, with i as the outer index.
- States:
  - IDLE: busy=0.
    - If start=1: capture a and b into internal registers. Product <= 0 if accumulate=0; otherwise product is held.
    - Compute per-chunk nonzero masks from the input a and b.
    - Load the pointer with the first valid pair. Go to CALC.
  - CALC: busy=1.
    - If a valid pair is pending: product <= product + ((a_i*b_j) << (CHUNK*(i+j))), then advance the pointer to the next valid pair.
    - When the current pair is the last valid pair, or no valid pair exists: next state IDLE and done <= 1.
- Arithmetic: unsigned. The accumulator wraps modulo 2^(2*WIDTH) in accumulate mode. In non-accumulate mode overflow is impossible.
- Next-valid-pair search is combinational (priority encoder over a K*K mask) and must skip any number of invalid pairs in one cycle.
- start during CALC is ignored; no queuing.
- Changes on a, b and accumulate during CALC have no effect.
- product is stable outside CALC and holds until the next accepted start.

## Timing
- P = number of valid pairs. The block spends N = max(1, P) cycles in CALC.
- Accepting edge t0 (IDLE, start=1): busy=1 during cycles t0+1 .. t0+N.
- Cycle t0+N+1: busy=0, done=1 for exactly one cycle, product final.
- A start seen in the same cycle as done is accepted. Back-to-back throughput is N+1 cycles per operation.
- With K=2 (default), N ranges 1..4. The worst case is K*K cycles.
- Reset asserted mid-operation: immediate IDLE with all outputs at reset values. The partial product is discarded and done is not pulsed.
- Reset deasserted with start=1: the first possible acceptance is the first rising edge after deassertion.

## Test plan
Default parameters (WIDTH=32, CHUNK=16) unless stated.
- a=0x0000_1234, b=0x0000_0010, acc=0 -> 1 busy cycle; done with product=0x0000_0000_0001_2340.
- a=0xFFFF_FFFF, b=0xFFFF_FFFF -> 4 busy cycles; product=0xFFFF_FFFE_0000_0001.
- a=0x0001_0000, b=0x0000_0003 -> only pair (1,0) valid, 1 busy cycle; product=0x0000_0000_0003_0000.
- a=0, b=0xDEAD_BEEF -> 1 busy cycle; product=0, done pulses.
- Accumulate chain:
  - a=2, b=3, acc=0 -> product=6.
  - Then a=4, b=5, acc=1 -> product=26.
  - Then a=b=0xFFFF_FFFF, acc=1 -> product = 26 + 0xFFFF_FFFE_0000_0001, no wrap.
- Robustness and parametrisation:
  - Start a 4-pair op, pulse start again and change a/b in CALC -> ignored, correct result.
  - Assert reset at the 2nd CALC cycle -> busy=0, product=0, no done.
  - Repeat with WIDTH=64, CHUNK=16: random operands against a reference model; cycle count = max(1, P).

Source files
------------

// File: rtl/mult_nxn_fast_if.sv
// Start/busy/done handshake and operand/product bus for the chunked multiplier.
interface mult_nxn_fast_if #(
   parameter int WIDTH = 32
);
   logic               start;
   logic               accumulate;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               busy;
   logic               done;
   logic [2*WIDTH-1:0] product;

   modport master (
      output start, accumulate, a, b,
      input  busy, done, product
   );

   modport slave (
      input  start, accumulate, a, b,
      output busy, done, product
   );
endinterface

// File: rtl/mult_nxn_fast.sv
// Multi-cycle unsigned multiplier: one nonzero CHUNKxCHUNK pair per cycle, max(1,P) busy cycles then a done pulse.
// No backpressure: start is accepted only in IDLE, ignored while busy; product holds until the next accepted start.
module mult_nxn_fast #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 16
) (
   input logic            clk,
   input logic            reset,
   mult_nxn_fast_if.slave bus
);
   localparam int K  = WIDTH / CHUNK;
   localparam int NP = K * K;
   localparam int PW = (NP > 1) ? $clog2(NP) : 1;

   typedef enum logic {S_IDLE, S_CALC} state_t;

   state_t             r_state;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [NP-1:0]      r_mask;
   logic [PW-1:0]      r_ptr;
   logic [2*WIDTH-1:0] r_product;
   logic               r_busy;
   logic               r_done;

   logic [NP-1:0]      w_in_mask;
   logic [NP-1:0]      w_rem;
   logic [CHUNK-1:0]   w_a_c;
   logic [CHUNK-1:0]   w_b_c;
   logic [2*CHUNK-1:0] w_pp_c;
   logic [2*WIDTH-1:0] w_pp;
   int                 w_sh;
   logic               w_pend;

   function automatic logic [PW-1:0] f_first(input logic [NP-1:0] m);
      f_first = '0;
      for (int p = NP - 1; p >= 0; p--) begin
         if (m[p]) f_first = PW'(p);
      end
   endfunction

   // Pair (i,j) lives at bit i*K+j, so ascending bit order is the visit order.
   always_comb begin
      w_in_mask = '0;
      for (int i = 0; i < K; i++) begin
         for (int j = 0; j < K; j++) begin
            w_in_mask[i*K+j] = (|bus.a[CHUNK*i +: CHUNK]) && (|bus.b[CHUNK*j +: CHUNK]);
         end
      end
   end

   always_comb begin
      w_a_c = '0;
      w_b_c = '0;
      w_sh  = 0;
      for (int p = 0; p < NP; p++) begin
         if (r_ptr == PW'(p)) begin
            w_a_c = r_a[CHUNK*(p/K) +: CHUNK];
            w_b_c = r_b[CHUNK*(p%K) +: CHUNK];
            w_sh  = CHUNK * ((p / K) + (p % K));
         end
      end
      w_pp_c = w_a_c * w_b_c;
      w_pp   = (2*WIDTH)'(w_pp_c) << w_sh;
      w_pend = r_mask[r_ptr];
      w_rem  = r_mask & ~(NP'(1) << r_ptr);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_a       <= '0;
         r_b       <= '0;
         r_mask    <= '0;
         r_ptr     <= '0;
         r_product <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_a     <= bus.a;
                  r_b     <= bus.b;
                  r_mask  <= w_in_mask;
                  r_ptr   <= f_first(w_in_mask);
                  r_busy  <= 1'b1;
                  r_state <= S_CALC;
                  if (!bus.accumulate) r_product <= '0;
               end
            end
            S_CALC: begin
               if (w_pend) r_product <= r_product + w_pp;
               r_mask <= w_rem;
               r_ptr  <= f_first(w_rem);
               // An empty mask still costs one CALC cycle.
               if (w_rem == '0) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
   assign bus.product = r_product;
endmodule
